icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the instruction fetcher and memctrl.
//  Hits return a 32-bit instruction one cycle after the request. Misses issue one
//  4-byte read on memctrl's icache port, fill the line and then return the instruction.
//  clear aborts an outstanding miss. Cache contents survive clear.
// PARAMETERS
//  INDEX_BITS  8   number of lines = 2**INDEX_BITS; one 32-bit word per line
//  ADDR_W      32  PC width; tag = pc[ADDR_W-1:INDEX_BITS+2], index = pc[INDEX_BITS+1:2]
// PORTS
//  clk                  in   1   clock
//  reset                in   1   asynchronous, active-low reset
//  ready                in   1   global ready; low freezes all state
//  clear                in   1   mispredict flush; synchronous, one cycle
//  if_in_flag           in   1   fetch request; held stable until if_out_flag
//  if_pc                in   32  fetch PC; bits [1:0] ignored
//  if_out_flag          out  1   one-cycle pulse: if_ins valid for current request
//  if_ins               out  32  fetched instruction
//  icache_mem_in_flag   out  1   read request to memctrl; held until icache_mem_out_flag
//  icache_mem_pc        out  32  word-aligned miss address
//  icache_mem_out_flag  in   1   memctrl completion pulse
//  icache_mem_ins       in   32  fill data, little-endian word
// BEHAVIOUR
//  Reset (reset==0, async): state=IDLE; all valid bits cleared; every output 0.
//  ready==0: no register, RAM or valid-bit update. Outputs hold their values.
//  FSM states, evaluated when ready==1 and clear==0:
//   IDLE: if_out_flag<=0.
//    - if_in_flag and hit (valid[idx] && tag match): if_ins<=data[idx], if_out_flag<=1,
//      stay IDLE. Hit latency = 1 cycle.
//    - if_in_flag and miss: latch pc; icache_mem_pc<={pc[31:2],2'b00};
//      icache_mem_in_flag<=1; go MISS.
//   MISS: hold icache_mem_in_flag and icache_mem_pc. if_in_flag is ignored.
//    - on icache_mem_out_flag: data[idx]<=icache_mem_ins; tag[idx]<=tag; valid[idx]<=1;
//      icache_mem_in_flag<=0 on the same edge (memctrl is in its stall cycle, so there is
//      no double issue); if_ins<=icache_mem_ins; if_out_flag<=1; go IDLE.
//      Miss latency = 1 cycle after the memctrl pulse.
//  A request arriving in the same cycle as a fill completes is not accepted. It is
//  evaluated on the next IDLE cycle, and then hits.
//  clear==1 (ready==1): if_out_flag<=0; icache_mem_in_flag<=0; state<=IDLE.
//   - if icache_mem_out_flag==1 in the same cycle while in MISS, the line is still written
//     (the data is correct) but is not returned to the fetcher.
//   - valid bits are unchanged. if_in_flag in the clear cycle is ignored.
//  A hit check never sees a half-written line: write and read of one index in one cycle
//  cannot occur, because a fill happens only in MISS and a lookup happens only in IDLE.
//  if_out_flag is never high for 2 consecutive cycles for the same request.
//  icache_mem_in_flag is high only in MISS.
// STRUCTURE
//  def.v (shared): `ICACHE_INDEX_BITS, `ICACHE_SIZE, state encodings `IC_IDLE/`IC_MISS;
//   reuse `ADDR_LEN / `INS_LEN.
//  One sub-module, icache_array: valid/tag/data storage with one read port (index) and one
//   synchronous write port. Valid bits are flops with async clear; data/tag may be
//   RAM-inferred. The FSM lives in icache.
// TESTING
//  1 Cold miss: pc=0x0000_1000 -> icache_mem_in_flag=1, icache_mem_pc=0x1000 next cycle;
//    memctrl model returns 0x0000_0513 -> if_out_flag pulse with if_ins=0x0000_0513.
//  2 Rehit: same pc again -> if_out_flag 1 cycle later, no icache_mem_in_flag assertion.
//  3 Conflict: pc=0x0000_1400 (same index as 0x1000 at INDEX_BITS=8) -> miss, refill;
//    then pc=0x1000 -> miss again.
//  4 Clear mid-miss: clear during MISS -> icache_mem_in_flag=0 next cycle, no if_out_flag;
//    next fetch of that pc misses.
//  5 Clear coincident with icache_mem_out_flag -> no if_out_flag; next fetch of that pc
//    hits with the filled word.
//  6 ready low for 3 cycles during MISS and on a hit -> all outputs frozen; behaviour
//    resumes exactly. Async reset mid-MISS -> all outputs 0 immediately; prior line misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;
   localparam int ADDR_LEN          = 32;
   localparam int INS_LEN           = 32;
   localparam int ICACHE_INDEX_BITS = 8;
   localparam int ICACHE_SIZE       = 1 << ICACHE_INDEX_BITS;

   typedef enum logic {
      IC_IDLE = 1'b0,
      IC_MISS = 1'b1
   } ic_state_e;
endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one combinational read port, one synchronous write port.
module icache_array #(
   parameter int INDEX_BITS = 8,
   parameter int TAG_W      = 22,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INDEX_BITS-1:0] rd_idx,
   output logic                  rd_valid,
   output logic [TAG_W-1:0]      rd_tag,
   output logic [DATA_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [INDEX_BITS-1:0] wr_idx,
   input  logic [TAG_W-1:0]      wr_tag,
   input  logic [DATA_W-1:0]     wr_data
);
   localparam int LINES = 1 << INDEX_BITS;

   logic [LINES-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];

   always_comb begin
      valid_d = valid_q;
      if (wr_en) valid_d[wr_idx] = 1'b1;
   end

   // Only the valid bits need reset; tag/data are don't-care until validated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_mem[rd_idx];
   assign rd_data  = data_mem[rd_idx];
endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, single-word refill from memctrl.
module icache
   import icache_pkg::*;
#(
   parameter int INDEX_BITS = ICACHE_INDEX_BITS,
   parameter int ADDR_W     = ADDR_LEN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ready,
   input  logic               clear,
   input  logic               if_in_flag,
   input  logic [ADDR_W-1:0]  if_pc,
   output logic               if_out_flag,
   output logic [INS_LEN-1:0] if_ins,
   output logic               icache_mem_in_flag,
   output logic [ADDR_W-1:0]  icache_mem_pc,
   input  logic               icache_mem_out_flag,
   input  logic [INS_LEN-1:0] icache_mem_ins
);
   localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

   ic_state_e          state_q, state_d;
   logic               if_out_flag_q, if_out_flag_d;
   logic [INS_LEN-1:0] if_ins_q, if_ins_d;
   logic               mem_in_flag_q, mem_in_flag_d;
   logic [ADDR_W-1:0]  mem_pc_q, mem_pc_d;

   logic               rd_valid, wr_en, hit;
   logic [TAG_W-1:0]   rd_tag;
   logic [INS_LEN-1:0] rd_data;

   // Lookup is indexed by the live PC; the fill uses the latched miss address.
   icache_array #(.INDEX_BITS(INDEX_BITS), .TAG_W(TAG_W), .DATA_W(INS_LEN)) u_array (
      .clk      (clk),
      .rst_n    (reset),
      .rd_idx   (if_pc[INDEX_BITS+1:2]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (wr_en),
      .wr_idx   (mem_pc_q[INDEX_BITS+1:2]),
      .wr_tag   (mem_pc_q[ADDR_W-1:INDEX_BITS+2]),
      .wr_data  (icache_mem_ins)
   );

   assign hit = rd_valid && (rd_tag == if_pc[ADDR_W-1:INDEX_BITS+2]);

   always_comb begin
      state_d       = state_q;
      if_out_flag_d = if_out_flag_q;
      if_ins_d      = if_ins_q;
      mem_in_flag_d = mem_in_flag_q;
      mem_pc_d      = mem_pc_q;
      wr_en         = 1'b0;
      if (ready) begin
         if (clear) begin
            // A fill landing with clear is still correct data: keep it, don't return it.
            if_out_flag_d = 1'b0;
            mem_in_flag_d = 1'b0;
            state_d       = IC_IDLE;
            wr_en         = (state_q == IC_MISS) && icache_mem_out_flag;
         end else begin
            unique case (state_q)
               IC_IDLE: begin
                  if_out_flag_d = 1'b0;
                  if (if_in_flag) begin
                     if (hit) begin
                        if_ins_d      = rd_data;
                        if_out_flag_d = 1'b1;
                     end else begin
                        mem_pc_d      = if_pc & ~ADDR_W'(3);
                        mem_in_flag_d = 1'b1;
                        state_d       = IC_MISS;
                     end
                  end
               end
               IC_MISS: begin
                  if (icache_mem_out_flag) begin
                     wr_en         = 1'b1;
                     mem_in_flag_d = 1'b0;
                     if_ins_d      = icache_mem_ins;
                     if_out_flag_d = 1'b1;
                     state_d       = IC_IDLE;
                  end
               end
               default: state_d = IC_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IC_IDLE;
         if_out_flag_q <= 1'b0;
         if_ins_q      <= '0;
         mem_in_flag_q <= 1'b0;
         mem_pc_q      <= '0;
      end else begin
         state_q       <= state_d;
         if_out_flag_q <= if_out_flag_d;
         if_ins_q      <= if_ins_d;
         mem_in_flag_q <= mem_in_flag_d;
         mem_pc_q      <= mem_pc_d;
      end
   end

   assign if_out_flag        = if_out_flag_q;
   assign if_ins             = if_ins_q;
   assign icache_mem_in_flag = mem_in_flag_q;
   assign icache_mem_pc      = mem_pc_q;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: misses, hits, conflicts, clear, ready stall, async reset.
module tb_icache;
   logic        clk = 1'b0;
   logic        reset, ready, clear, if_in_flag;
   logic [31:0] if_pc;
   logic        if_out_flag;
   logic [31:0] if_ins;
   logic        icache_mem_in_flag;
   logic [31:0] icache_mem_pc;
   logic        icache_mem_out_flag;
   logic [31:0] icache_mem_ins;

   int n_chk  = 0;
   int n_fail = 0;

   icache dut (
      .clk                 (clk),
      .reset               (reset),
      .ready               (ready),
      .clear               (clear),
      .if_in_flag          (if_in_flag),
      .if_pc               (if_pc),
      .if_out_flag         (if_out_flag),
      .if_ins              (if_ins),
      .icache_mem_in_flag  (icache_mem_in_flag),
      .icache_mem_pc       (icache_mem_pc),
      .icache_mem_out_flag (icache_mem_out_flag),
      .icache_mem_ins      (icache_mem_ins)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic of, input logic [31:0] ins,
                          input logic mf);
      chk({tag, ".out_flag"}, {31'd0, if_out_flag}, {31'd0, of});
      chk({tag, ".ins"}, if_ins, ins);
      chk({tag, ".mem_in"}, {31'd0, icache_mem_in_flag}, {31'd0, mf});
   endtask

   initial begin
      reset = 1'b0; ready = 1'b1; clear = 1'b0; if_in_flag = 1'b0; if_pc = '0;
      icache_mem_out_flag = 1'b0; icache_mem_ins = '0;
      tick(); tick();
      chk_out("reset", 1'b0, 32'h0, 1'b0);
      chk("reset.mem_pc", icache_mem_pc, 32'h0);
      reset = 1'b1;
      tick();

      // 1 cold miss
      if_in_flag = 1'b1; if_pc = 32'h0000_1000;
      tick();
      chk_out("cold.req", 1'b0, 32'h0, 1'b1);
      chk("cold.mem_pc", icache_mem_pc, 32'h0000_1000);
      tick();
      chk_out("cold.wait", 1'b0, 32'h0, 1'b1);
      icache_mem_out_flag = 1'b1; icache_mem_ins = 32'h0000_0513;
      tick();
      chk_out("cold.fill", 1'b1, 32'h0000_0513, 1'b0);
      icache_mem_out_flag = 1'b0; if_in_flag = 1'b0;
      tick();
      chk_out("cold.after", 1'b0, 32'h0000_0513, 1'b0);

      // 2 rehit
      if_in_flag = 1'b1; if_pc = 32'h0000_1000;
      tick();
      chk_out("rehit", 1'b1, 32'h0000_0513, 1'b0);
      if_in_flag = 1'b0;
      tick();
      chk_out("rehit.after", 1'b0, 32'h0000_0513, 1'b0);

      // 3 conflict at index 0
      if_in_flag = 1'b1; if_pc = 32'h0000_1400;
      tick();
      chk_out("conf.req", 1'b0, 32'h0000_0513, 1'b1);
      chk("conf.mem_pc", icache_mem_pc, 32'h0000_1400);
      icache_mem_out_flag = 1'b1; icache_mem_ins = 32'hAAAA_0001;
      tick();
      chk_out("conf.fill", 1'b1, 32'hAAAA_0001, 1'b0);
      icache_mem_out_flag = 1'b0; if_pc = 32'h0000_1000;
      tick();
      chk_out("conf.remiss", 1'b0, 32'hAAAA_0001, 1'b1);
      chk("conf.remiss_pc", icache_mem_pc, 32'h0000_1000);
      icache_mem_out_flag = 1'b1; icache_mem_ins = 32'h0000_0513;
      tick();
      chk_out("conf.refill", 1'b1, 32'h0000_0513, 1'b0);
      icache_mem_out_flag = 1'b0; if_in_flag = 1'b0;
      tick();

      // 4 clear mid-miss; low PC bits must be dropped from the miss address
      if_in_flag = 1'b1; if_pc = 32'h0000_2006;
      tick();
      chk_out("clr.req", 1'b0, 32'h0000_0513, 1'b1);
      chk("clr.mem_pc", icache_mem_pc, 32'h0000_2004);
      clear = 1'b1; if_in_flag = 1'b0;
      tick();
      chk_out("clr.abort", 1'b0, 32'h0000_0513, 1'b0);
      clear = 1'b0;
      tick();
      chk_out("clr.idle", 1'b0, 32'h0000_0513, 1'b0);
      if_in_flag = 1'b1; if_pc = 32'h0000_2004;
      tick();
      chk_out("clr.remiss", 1'b0, 32'h0000_0513, 1'b1);
      icache_mem_out_flag = 1'b1; icache_mem_ins = 32'h1111_2222;
      tick();
      chk_out("clr.fill", 1'b1, 32'h1111_2222, 1'b0);
      icache_mem_out_flag = 1'b0; if_in_flag = 1'b0;
      tick();

      // 5 clear coincident with fill: line written but not returned
      if_in_flag = 1'b1; if_pc = 32'h0000_3008;
      tick();
      chk_out("cfill.req", 1'b0, 32'h1111_2222, 1'b1);
      clear = 1'b1; if_in_flag = 1'b0;
      icache_mem_out_flag = 1'b1; icache_mem_ins = 32'hDEAD_BEEF;
      tick();
      chk_out("cfill.clr", 1'b0, 32'h1111_2222, 1'b0);
      clear = 1'b0; icache_mem_out_flag = 1'b0;
      if_in_flag = 1'b1; if_pc = 32'h0000_3008;
      tick();
      chk_out("cfill.hit", 1'b1, 32'hDEAD_BEEF, 1'b0);
      if_in_flag = 1'b0;
      tick();

      // 6a ready low during MISS; a memctrl pulse while frozen is ignored
      if_in_flag = 1'b1; if_pc = 32'h0000_400C;
      tick();
      chk_out("rdy.miss", 1'b0, 32'hDEAD_BEEF, 1'b1);
      ready = 1'b0; icache_mem_out_flag = 1'b1; icache_mem_ins = 32'h5555_5555;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("rdy.frozen_miss", 1'b0, 32'hDEAD_BEEF, 1'b1);
         chk("rdy.frozen_pc", icache_mem_pc, 32'h0000_400C);
      end
      ready = 1'b1; icache_mem_out_flag = 1'b0;
      tick();
      chk_out("rdy.resume", 1'b0, 32'hDEAD_BEEF, 1'b1);
      icache_mem_out_flag = 1'b1; icache_mem_ins = 32'h7777_0001;
      tick();
      chk_out("rdy.fill", 1'b1, 32'h7777_0001, 1'b0);
      icache_mem_out_flag = 1'b0; if_in_flag = 1'b0;
      tick();

      // 6b ready low on a hit: pulse held while frozen, then drops
      if_in_flag = 1'b1; if_pc = 32'h0000_1000;
      tick();
      chk_out("rdyhit", 1'b1, 32'h0000_0513, 1'b0);
      ready = 1'b0; if_in_flag = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("rdyhit.frozen", 1'b1, 32'h0000_0513, 1'b0);
      end
      ready = 1'b1;
      tick();
      chk_out("rdyhit.resume", 1'b0, 32'h0000_0513, 1'b0);

      // 6c async reset mid-MISS, then a previously cached line misses
      if_in_flag = 1'b1; if_pc = 32'h0000_5010;
      tick();
      chk_out("arst.miss", 1'b0, 32'h0000_0513, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk_out("arst.now", 1'b0, 32'h0, 1'b0);
      chk("arst.mem_pc", icache_mem_pc, 32'h0);
      if_in_flag = 1'b0;
      tick();
      reset = 1'b1;
      if_in_flag = 1'b1; if_pc = 32'h0000_1000;
      tick();
      chk_out("arst.cold", 1'b0, 32'h0, 1'b1);
      chk("arst.cold_pc", icache_mem_pc, 32'h0000_1000);
      clear = 1'b1; if_in_flag = 1'b0;
      tick();
      clear = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
